sap_register_file: RTL and testbench

- Parametrised successor to the single SAP-1 B register: a bank of DEPTH general registers, each WIDTH bits, on the shared data bus.
- Each register can be loaded from the bus or driven onto it, selected by index.
- Each register can also be incremented, decremented or shifted in place; the bank reports registered zero and carry flags.
- Sits between the bus and the ALU/controller. The controller's load/enable control word is unchanged, with select fields added.

---
 rtl/sap_register_file_if.sv | 24 ++
 rtl/sap_register_file.sv | 54 +++++
 tb/tb_sap_register_file.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sap_register_file_if.sv
// sap_register_file_if: controller-side control word and bus signals of the register bank
// load/load_sel/data_in_bus: write the bus into a register; enable/enable_sel: read a register onto the bus
// op/op_sel: in-place increment/decrement/shift; data_out_bus/bus_drive: read result; zero_flag/carry_flag: op flags
interface sap_register_file_if #(parameter int WIDTH = 8, parameter int SEL_W = 2);
  logic             load;
  logic [SEL_W-1:0] load_sel;
  logic             enable;
  logic [SEL_W-1:0] enable_sel;
  logic [1:0]       op;
  logic [SEL_W-1:0] op_sel;
  logic [WIDTH-1:0] data_in_bus;
  logic [WIDTH-1:0] data_out_bus;
  logic             bus_drive;
  logic             zero_flag;
  logic             carry_flag;
  modport master (
    output load, load_sel, enable, enable_sel, op, op_sel, data_in_bus,
    input  data_out_bus, bus_drive, zero_flag, carry_flag
  );
  modport slave (
    input  load, load_sel, enable, enable_sel, op, op_sel, data_in_bus,
    output data_out_bus, bus_drive, zero_flag, carry_flag
  );
endinterface

// File: rtl/sap_register_file.sv
// sap_register_file: DEPTH x WIDTH register bank with bus load/read, in-place inc/dec/shift and registered flags
// clk: rising-edge clock; rst: synchronous active-low reset; bus: slave side of sap_register_file_if
module sap_register_file #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = 2
) (
  input logic clk,
  input logic rst,
  sap_register_file_if.slave bus
);
  localparam logic [SEL_W:0] LIMIT = (SEL_W+1)'(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] op_old;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH:0]   op_res;
  logic             op_ok;
  logic             drive;
  logic             zero_q;
  logic             carry_q;
  always_comb begin
    op_old = '0;
    rd_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      op_old = bus.op_sel == SEL_W'(i) ? regs[i] : op_old;
      rd_val = bus.enable_sel == SEL_W'(i) ? regs[i] : rd_val;
    end
  end
  // a load to the same index cancels the op, including its flag update
  assign op_ok  = bus.op != 2'b00 && {1'b0, bus.op_sel} < LIMIT && !(bus.load && bus.load_sel == bus.op_sel);
  // the extra top bit carries the overflow, the borrow, or the shifted-out MSB
  assign op_res = bus.op == 2'b01 ? {1'b0, op_old} + (WIDTH+1)'(1) :
                  bus.op == 2'b10 ? {1'b0, op_old} - (WIDTH+1)'(1) : {op_old, 1'b0};
  assign drive            = bus.enable && {1'b0, bus.enable_sel} < LIMIT;
  assign bus.bus_drive    = drive;
  assign bus.data_out_bus = drive ? rd_val : '0;
  assign bus.zero_flag    = zero_q;
  assign bus.carry_flag   = carry_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= bus.load && bus.load_sel == SEL_W'(i) ? bus.data_in_bus :
                   op_ok && bus.op_sel == SEL_W'(i) ? op_res[WIDTH-1:0] : regs[i];
      if (op_ok) begin
        zero_q  <= op_res[WIDTH-1:0] == '0;
        carry_q <= op_res[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_sap_register_file.sv
// tb_sap_register_file: scoreboard bench for a DEPTH=4 bank and a DEPTH=3 bank (out-of-range selects)
module tb_sap_register_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sap_register_file_if #(.WIDTH(8), .SEL_W(2)) ia ();
  sap_register_file_if #(.WIDTH(8), .SEL_W(2)) ib ();
  sap_register_file #(.WIDTH(8), .DEPTH(4), .SEL_W(2)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  sap_register_file #(.WIDTH(8), .DEPTH(3), .SEL_W(2)) dut_b (.clk(clk), .rst(rst), .bus(ib));
  localparam int DA = 0, BA = 1, ZA = 2, CA = 3, DB = 4, BB = 5, ZB = 6, CB = 7;
  typedef struct { string tag; int id; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs(input int id);
    return id == DA ? 32'(ia.data_out_bus) : id == BA ? 32'(ia.bus_drive) :
           id == ZA ? 32'(ia.zero_flag) : id == CA ? 32'(ia.carry_flag) :
           id == DB ? 32'(ib.data_out_bus) : id == BB ? 32'(ib.bus_drive) :
           id == ZB ? 32'(ib.zero_flag) : 32'(ib.carry_flag);
  endfunction
  task automatic push_exp(input string tag, input int id, input logic [31:0] val);
    sb.push_back('{tag, id, val});
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.id), e.val);
    end
  endtask
  task automatic settle();
    #1;
    drain();
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask
  task automatic idle();
    ia.load = 0; ia.load_sel = 0; ia.enable = 0; ia.enable_sel = 0; ia.op = 0; ia.op_sel = 0; ia.data_in_bus = 0;
    ib.load = 0; ib.load_sel = 0; ib.enable = 0; ib.enable_sel = 0; ib.op = 0; ib.op_sel = 0; ib.data_in_bus = 0;
  endtask
  task automatic load_a(input logic [1:0] sel, input logic [7:0] val);
    idle();
    ia.load = 1; ia.load_sel = sel; ia.data_in_bus = val;
    tick();
  endtask
  task automatic op_a(input logic [1:0] op, input logic [1:0] sel, input logic z, input logic c, input string tag);
    idle();
    ia.op = op; ia.op_sel = sel;
    push_exp({tag, "_zero"}, ZA, z);
    push_exp({tag, "_carry"}, CA, c);
    tick();
  endtask
  task automatic rd_a(input logic [1:0] sel, input logic [7:0] val, input string tag);
    idle();
    ia.enable = 1; ia.enable_sel = sel;
    push_exp(tag, DA, val);
    push_exp({tag, "_drv"}, BA, 1);
    settle();
  endtask
  task automatic rd_b(input logic [1:0] sel, input logic [7:0] val, input logic drv, input string tag);
    idle();
    ib.enable = 1; ib.enable_sel = sel;
    push_exp(tag, DB, val);
    push_exp({tag, "_drv"}, BB, drv);
    settle();
  endtask
  initial begin
    idle();
    tick();
    rst = 1;
    push_exp("rst_zero", ZA, 0);
    push_exp("rst_carry", CA, 0);
    settle();
    for (int i = 0; i < 4; i++) rd_a(2'(i), 8'h00, $sformatf("rst_reg%0d", i));
    load_a(1, 8'hAA);
    rd_a(1, 8'hAA, "load_reg1");
    rd_a(0, 8'h00, "load_reg0_untouched");
    idle();
    push_exp("idle_out", DA, 0);
    push_exp("idle_drv", BA, 0);
    settle();
    load_a(2, 8'hFF);
    op_a(2'b01, 2, 1, 1, "inc_wrap");
    rd_a(2, 8'h00, "inc_wrap_val");
    idle();
    ia.op = 2'b01; ia.op_sel = 2; ia.enable = 1; ia.enable_sel = 2;
    push_exp("inc_pre_op_out", DA, 8'h00);
    settle();
    push_exp("inc2_post_out", DA, 8'h01);
    push_exp("inc2_zero", ZA, 0);
    push_exp("inc2_carry", CA, 0);
    tick();
    load_a(3, 8'h00);
    op_a(2'b10, 3, 0, 1, "dec_borrow");
    rd_a(3, 8'hFF, "dec_val");
    load_a(3, 8'hCC);
    push_exp("load_keeps_zero", ZA, 0);
    push_exp("load_keeps_carry", CA, 1);
    settle();
    op_a(2'b11, 3, 0, 1, "shl_cc");
    rd_a(3, 8'h98, "shl_cc_val");
    op_a(2'b11, 3, 0, 1, "shl_98");
    op_a(2'b11, 3, 0, 0, "shl_30");
    rd_a(3, 8'h60, "shl_30_val");
    load_a(3, 8'h80);
    op_a(2'b11, 3, 1, 1, "shl_80");
    rd_a(3, 8'h00, "shl_80_val");
    op_a(2'b00, 3, 1, 1, "hold");
    rd_a(3, 8'h00, "hold_val");
    idle();
    ia.load = 1; ia.load_sel = 0; ia.data_in_bus = 8'h55; ia.op = 2'b01; ia.op_sel = 0;
    push_exp("ld_op_zero", ZA, 1);
    push_exp("ld_op_carry", CA, 1);
    tick();
    rd_a(0, 8'h55, "ld_wins_val");
    idle();
    ia.load = 1; ia.load_sel = 0; ia.data_in_bus = 8'h11; ia.enable = 1; ia.enable_sel = 0;
    push_exp("en_ld_pre", DA, 8'h55);
    settle();
    push_exp("en_ld_post", DA, 8'h11);
    tick();
    idle();
    ia.load = 1; ia.load_sel = 1; ia.data_in_bus = 8'h22; ia.op = 2'b10; ia.op_sel = 0;
    push_exp("ld_op_diff_zero", ZA, 0);
    push_exp("ld_op_diff_carry", CA, 0);
    tick();
    rd_a(1, 8'h22, "ld_diff_val");
    rd_a(0, 8'h10, "op_diff_val");
    op_a(2'b10, 3, 0, 1, "pre_rst_dec");
    idle();
    rst = 0;
    ia.load = 1; ia.load_sel = 0; ia.data_in_bus = 8'h77; ia.op = 2'b01; ia.op_sel = 1;
    push_exp("midrst_zero", ZA, 0);
    push_exp("midrst_carry", CA, 0);
    tick();
    rst = 1;
    for (int i = 0; i < 4; i++) rd_a(2'(i), 8'h00, $sformatf("midrst_reg%0d", i));
    idle();
    ib.load = 1; ib.load_sel = 2; ib.data_in_bus = 8'h3C;
    tick();
    idle();
    ib.load = 1; ib.load_sel = 3; ib.data_in_bus = 8'h5A; ib.op = 2'b01; ib.op_sel = 3;
    push_exp("oor_zero", ZB, 0);
    push_exp("oor_carry", CB, 0);
    tick();
    idle();
    ib.op = 2'b10; ib.op_sel = 3;
    push_exp("oor_dec_zero", ZB, 0);
    push_exp("oor_dec_carry", CB, 0);
    tick();
    rd_b(3, 8'h00, 0, "oor_read");
    rd_b(2, 8'h3C, 1, "b_reg2");
    rd_b(0, 8'h00, 1, "b_reg0");
    rd_b(1, 8'h00, 1, "b_reg1");
    idle();
    ib.op = 2'b10; ib.op_sel = 2;
    push_exp("b_dec_zero", ZB, 0);
    push_exp("b_dec_carry", CB, 0);
    tick();
    rd_b(2, 8'h3B, 1, "b_dec_val");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
